mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single burst-oriented main-memory port.
// Runs one command phase, then a counted data burst, then a one-cycle completion pulse.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_cmd_ack,
  input  logic              mem_beat,
  output logic [9:0]        beat_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [9:0] LAST_BEAT = 10'(BURST_LEN - 1);

  state_t              state_q, state_d;
  logic [1:0]          gnt_d, done_d;
  logic                valid_d, wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [9:0]          cnt_d;
  logic                last_win_q, last_win_d;
  logic                pick;

  // Winner index: a lone request wins; a tie goes to whoever did not win last.
  assign pick = (req == 2'b11) ? ~last_win_q : req[1];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    gnt_d      = gnt;
    done_d     = 2'b00;
    valid_d    = mem_cmd_valid;
    wr_d       = mem_cmd_wr;
    addr_d     = mem_cmd_addr;
    cnt_d      = beat_cnt;
    last_win_d = last_win_q;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          state_d = CMD;
          gnt_d   = pick ? 2'b10 : 2'b01;
          wr_d    = pick ? req_wr[1] : req_wr[0];
          addr_d  = pick ? req1_addr : req0_addr;
          valid_d = 1'b1;
        end
      end
      CMD: begin
        if (mem_cmd_ack) begin
          state_d = XFER;
          valid_d = 1'b0;
        end
      end
      XFER: begin
        if (mem_beat) begin
          if (beat_cnt == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = 10'd0;
            done_d  = gnt;
          end else begin
            cnt_d = beat_cnt + 10'd1;
          end
        end
      end
      DONE: begin
        last_win_d = gnt[1];
        gnt_d      = 2'b00;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt           <= 2'b00;
      done          <= 2'b00;
      mem_cmd_valid <= 1'b0;
      mem_cmd_wr    <= 1'b0;
      mem_cmd_addr  <= '0;
      beat_cnt      <= 10'd0;
      last_win_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      gnt           <= gnt_d;
      done          <= done_d;
      mem_cmd_valid <= valid_d;
      mem_cmd_wr    <= wr_d;
      mem_cmd_addr  <= addr_d;
      beat_cnt      <= cnt_d;
      last_win_q    <= last_win_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
